// File: rtl/dsss_pkg.sv
// Shared definitions for the despread receive path: default widths,
// decider state encoding and the correlation metric width helper.
package dsss_pkg;

  localparam int SUM_W_DEF  = 10;
  localparam int WORD_W_DEF = 8;

  typedef enum logic {
    UNLOCK = 1'b0,
    PACK   = 1'b1
  } dec_state_e;

  // I+Q sum needs one extra bit so it can never wrap
  function automatic int metric_w(input int sum_w);
    return sum_w + 1;
  endfunction

endpackage

// File: rtl/bit_packer.sv
// Packs per-symbol decisions into words (first symbol in bit 0) behind a
// one-deep ready/valid output register with sticky drop detection.
module bit_packer
  import dsss_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              take,
  input  logic              bit_in,
  input  logic              erase_in,
  input  logic              word_ready,
  input  logic              clr_overflow,
  output logic [WORD_W-1:0] word_data,
  output logic [WORD_W-1:0] word_erase,
  output logic              word_valid,
  output logic              overflow
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] sh_bits;
  logic [WORD_W-1:0] sh_erase;
  logic              complete;
  logic              load;
  logic              drop;

  assign complete = take && (idx == IDX_LAST);
  // accept and reload in the same cycle keeps the stream gap-free
  assign load     = complete && (!word_valid || word_ready);
  assign drop     = complete && !load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      sh_bits    <= '0;
      sh_erase   <= '0;
      word_data  <= '0;
      word_erase <= '0;
      word_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (clr) begin
        idx      <= '0;
        sh_bits  <= '0;
        sh_erase <= '0;
      end else if (take) begin
        idx      <= complete ? '0 : idx + 1'b1;
        sh_bits  <= {bit_in, sh_bits[WORD_W-1:1]};
        sh_erase <= {erase_in, sh_erase[WORD_W-1:1]};
      end

      if (load) begin
        word_data  <= {bit_in, sh_bits[WORD_W-1:1]};
        word_erase <= {erase_in, sh_erase[WORD_W-1:1]};
        word_valid <= 1'b1;
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end

      if (drop)
        overflow <= 1'b1;
      else if (clr_overflow)
        overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/symbol_decider.sv
// Hard decision plus erasure flag per despread symbol, gated by the
// synchroniser lock, feeding the word packer.
//
//   state  | meaning
//   UNLOCK | no lock: symbols ignored, packer held at index 0
//   PACK   | locked: each sum_valid yields a decision and a packed bit
module symbol_decider
  import dsss_pkg::*;
#(
  parameter int SUM_W    = SUM_W_DEF,
  parameter int WORD_W   = WORD_W_DEF,
  parameter int ERASE_TH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flag,
  input  logic signed [SUM_W-1:0] sum_i,
  input  logic signed [SUM_W-1:0] sum_q,
  input  logic                    sum_valid,
  output logic                    dec_bit,
  output logic                    dec_erase,
  output logic                    dec_valid,
  output logic [WORD_W-1:0]       word_data,
  output logic [WORD_W-1:0]       word_erase,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic                    overflow,
  input  logic                    clr_overflow
);

  localparam int MW = metric_w(SUM_W);
  localparam logic [MW-1:0] TH = MW'(ERASE_TH);

  dec_state_e            state;
  logic signed [MW-1:0]  metric;
  logic        [MW-1:0]  mag;
  logic                  bit_d;
  logic                  erase_d;
  logic                  take;
  logic                  clr;

  assign metric  = {sum_i[SUM_W-1], sum_i} + {sum_q[SUM_W-1], sum_q};
  assign mag     = metric[MW-1] ? -metric : metric;
  assign bit_d   = !metric[MW-1] && (metric != '0);
  assign erase_d = (ERASE_TH != 0) && (mag < TH);

  // a symbol coinciding with the falling lock is discarded with the partial word
  assign take = (state == PACK) && flag && sum_valid;
  assign clr  = (state == UNLOCK) || !flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= UNLOCK;
      dec_bit   <= 1'b0;
      dec_erase <= 1'b0;
      dec_valid <= 1'b0;
    end else begin
      case (state)
        UNLOCK:  if (flag) state <= PACK;
        PACK:    if (!flag) state <= UNLOCK;
        default: state <= UNLOCK;
      endcase
      dec_valid <= take;
      dec_bit   <= take && bit_d;
      dec_erase <= take && erase_d;
    end
  end

  bit_packer #(.WORD_W(WORD_W)) u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .take         (take),
    .bit_in       (bit_d),
    .erase_in     (erase_d),
    .word_ready   (word_ready),
    .clr_overflow (clr_overflow),
    .word_data    (word_data),
    .word_erase   (word_erase),
    .word_valid   (word_valid),
    .overflow     (overflow)
  );

endmodule

// File: tb/tb_symbol_decider.sv
// Bench for symbol_decider: table-driven symbol vectors with a decision
// scoreboard, plus directed sequences for packing, overflow, lock and reset.
module tb_symbol_decider;

  localparam int SUM_W  = 10;
  localparam int WORD_W = 8;

  logic                    clk;
  logic                    rst_n;
  logic                    flag;
  logic signed [SUM_W-1:0] sum_i;
  logic signed [SUM_W-1:0] sum_q;
  logic                    sum_valid;
  logic                    dec_bit;
  logic                    dec_erase;
  logic                    dec_valid;
  logic [WORD_W-1:0]       word_data;
  logic [WORD_W-1:0]       word_erase;
  logic                    word_valid;
  logic                    word_ready;
  logic                    overflow;
  logic                    clr_overflow;

  symbol_decider #(.SUM_W(SUM_W), .WORD_W(WORD_W), .ERASE_TH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flag         (flag),
    .sum_i        (sum_i),
    .sum_q        (sum_q),
    .sum_valid    (sum_valid),
    .dec_bit      (dec_bit),
    .dec_erase    (dec_erase),
    .dec_valid    (dec_valid),
    .word_data    (word_data),
    .word_erase   (word_erase),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   i;
    int   q;
    logic b;
    logic e;
  } vec_t;

  typedef struct packed {
    logic b;
    logic e;
  } dec_t;

  vec_t tbl[16];
  dec_t exp_q[$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // drive one symbol for a cycle; push the expected decision if one is due
  task automatic sym(input int i, input int q, input logic b, input logic e, input bit expect_dec);
    dec_t d;
    sum_i     = SUM_W'(i);
    sum_q     = SUM_W'(q);
    sum_valid = 1'b1;
    if (expect_dec) begin
      d.b = b;
      d.e = e;
      exp_q.push_back(d);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    sum_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    dec_t d;
    if (dec_valid) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL dec_unexpected: got dec_valid=1 expected 0 at %0t", $time);
      end else begin
        d = exp_q.pop_front();
        chk("dec_bit", 32'(dec_bit), 32'(d.b));
        chk("dec_erase", 32'(dec_erase), 32'(d.e));
      end
    end
  end

  initial begin
    logic [WORD_W-1:0] wb;
    logic [WORD_W-1:0] we;

    tbl[0]  = '{5, 5, 1'b1, 1'b1};
    tbl[1]  = '{-30, -2, 1'b0, 1'b0};
    tbl[2]  = '{0, 0, 1'b0, 1'b1};
    tbl[3]  = '{3, -3, 1'b0, 1'b1};
    tbl[4]  = '{-511, -512, 1'b0, 1'b0};
    tbl[5]  = '{511, 511, 1'b1, 1'b0};
    tbl[6]  = '{8, 7, 1'b1, 1'b1};
    tbl[7]  = '{8, 8, 1'b1, 1'b0};
    tbl[8]  = '{-8, -8, 1'b0, 1'b0};
    tbl[9]  = '{-8, -7, 1'b0, 1'b1};
    tbl[10] = '{-1, 1, 1'b0, 1'b1};
    tbl[11] = '{1, 0, 1'b1, 1'b1};
    tbl[12] = '{40, 10, 1'b1, 1'b0};
    tbl[13] = '{-40, 10, 1'b0, 1'b0};
    tbl[14] = '{-16, 0, 1'b0, 1'b0};
    tbl[15] = '{15, 0, 1'b1, 1'b1};

    rst_n = 1'b0; flag = 1'b0; sum_i = '0; sum_q = '0; sum_valid = 1'b0;
    word_ready = 1'b0; clr_overflow = 1'b0;
    #12;
    chk("rst_dec_valid", 32'(dec_valid), 0);
    chk("rst_word_valid", 32'(word_valid), 0);
    chk("rst_word_data", 32'(word_data), 0);
    chk("rst_overflow", 32'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // all-positive word, ready held high
    flag = 1'b1;
    word_ready = 1'b1;
    idle(1);
    for (int k = 0; k < 8; k++) sym(40, 10, 1'b1, 1'b0, 1'b1);
    chk("t1_word_valid", 32'(word_valid), 1);
    chk("t1_word_data", 32'(word_data), 32'hFF);
    chk("t1_word_erase", 32'(word_erase), 32'h00);
    idle(2);
    chk("t1_popped", 32'(word_valid), 0);

    // table vectors back-to-back, two words
    wb = '0; we = '0;
    for (int k = 0; k < 16; k++) begin
      wb[k % 8] = tbl[k].b;
      we[k % 8] = tbl[k].e;
      sym(tbl[k].i, tbl[k].q, tbl[k].b, tbl[k].e, 1'b1);
      if (k % 8 == 7) begin
        chk("t2_word_valid", 32'(word_valid), 1);
        chk("t2_word_data", 32'(word_data), 32'(wb));
        chk("t2_word_erase", 32'(word_erase), 32'(we));
      end
    end
    idle(2);

    // overflow: first word held, second dropped
    word_ready = 1'b0;
    for (int k = 0; k < 8; k++) sym(40, 10, 1'b1, 1'b0, 1'b1);
    chk("t3_held_valid", 32'(word_valid), 1);
    chk("t3_no_ovf_yet", 32'(overflow), 0);
    for (int k = 0; k < 8; k++) sym(-40, -10, 1'b0, 1'b0, 1'b1);
    idle(1);
    chk("t3_overflow", 32'(overflow), 1);
    chk("t3_kept_data", 32'(word_data), 32'hFF);
    clr_overflow = 1'b1;
    idle(1);
    clr_overflow = 1'b0;
    chk("t3_ovf_cleared", 32'(overflow), 0);
    clr_overflow = 1'b1;
    for (int k = 0; k < 8; k++) sym(-40, -10, 1'b0, 1'b0, 1'b1);
    clr_overflow = 1'b0;
    chk("t3_set_wins", 32'(overflow), 1);
    chk("t3_kept_data2", 32'(word_data), 32'hFF);

    // completion coinciding with accept of the held word
    clr_overflow = 1'b1;
    idle(1);
    clr_overflow = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) word_ready = 1'b1;
      if (k % 2 == 0) sym(40, 10, 1'b1, 1'b0, 1'b1);
      else            sym(-40, -10, 1'b0, 1'b0, 1'b1);
    end
    chk("t4_word_valid", 32'(word_valid), 1);
    chk("t4_word_data", 32'(word_data), 32'h55);
    chk("t4_overflow", 32'(overflow), 0);
    idle(1);
    chk("t4_popped", 32'(word_valid), 0);

    // lock drop after 5 symbols, unlocked symbols ignored, relock
    for (int k = 0; k < 5; k++) sym(-40, -10, 1'b0, 1'b0, 1'b1);
    flag = 1'b0;
    sym(40, 10, 1'b1, 1'b0, 1'b0);
    sym(40, 10, 1'b1, 1'b0, 1'b0);
    sym(40, 10, 1'b1, 1'b0, 1'b0);
    flag = 1'b1;
    sym(40, 10, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) sym(40, 10, 1'b1, 1'b0, 1'b1);
    chk("t5_no_partial", 32'(word_valid), 0);
    sym(40, 10, 1'b1, 1'b0, 1'b1);
    chk("t5_word_valid", 32'(word_valid), 1);
    chk("t5_word_data", 32'(word_data), 32'hFF);
    chk("t5_word_erase", 32'(word_erase), 32'h00);
    idle(2);

    // async reset with a held word and idx=3
    word_ready = 1'b0;
    for (int k = 0; k < 11; k++) sym(40, 10, 1'b1, 1'b0, 1'b1);
    sum_valid = 1'b0;
    chk("t6_pre_valid", 32'(word_valid), 1);
    chk("t6_pre_dec", 32'(dec_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_word_valid", 32'(word_valid), 0);
    chk("t6_word_data", 32'(word_data), 0);
    chk("t6_dec_valid", 32'(dec_valid), 0);
    chk("t6_dec_bit", 32'(dec_bit), 0);
    chk("t6_overflow", 32'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    chk("t6_post_valid", 32'(word_valid), 0);

    nvec++;
    if (exp_q.size() != 0) begin
      nerr++;
      $display("FAIL dec_missing: got %0d outstanding decisions expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
